// File: rtl/mem_access_unit.sv
// Load/store unit between the execute stage and the data bus: handles
// byte/half/word accesses plus the MIPS unaligned LWL/LWR/SWL/SWR forms.
module mem_access_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_write,
    input  logic        mem_sig,
    input  logic [1:0]  mem_msize,
    input  logic [1:0]  mem_kind,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rt_old,
    output logic        dreq_valid,
    output logic [31:0] dreq_addr,
    output logic [1:0]  dreq_size,
    output logic [3:0]  dreq_strobe,
    output logic [31:0] dreq_data,
    input  logic        dreq_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [31:0] dresp_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        misalign
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    localparam logic [1:0] KIND_LEFT  = 2'd1;
    localparam logic [1:0] KIND_RIGHT = 2'd2;

    state_t      state;
    logic        op_write;
    logic        op_sig;
    logic [1:0]  op_msize;
    logic [1:0]  op_kind;
    logic [1:0]  op_off;
    logic [31:0] op_rt;

    logic [1:0]  off_in;
    logic [1:0]  inv_off;
    logic        is_lr;
    logic        is_mis;
    logic [31:0] next_addr;
    logic [1:0]  next_size;
    logic [3:0]  next_strobe;
    logic [31:0] next_data;
    logic [31:0] shifted;
    logic [31:0] load_result;

    assign req_ready  = (state == S_IDLE);
    assign dreq_valid = (state == S_REQ);

    // Bus request fields are decoded from the live inputs and registered at acceptance.
    always_comb begin
        off_in      = addr[1:0];
        inv_off     = 2'd3 - off_in;
        is_lr       = (mem_kind == KIND_LEFT) || (mem_kind == KIND_RIGHT);
        is_mis      = (mem_kind == 2'd0) &&
                      (((mem_msize == 2'd1) && addr[0]) ||
                       ((mem_msize == 2'd2) && (addr[1:0] != 2'd0)));
        next_addr   = is_lr ? {addr[31:2], 2'b00} : addr;
        next_size   = is_lr ? 2'd2 : mem_msize;
        next_strobe = 4'b0000;
        next_data   = 32'd0;
        if (mem_write) begin
            if (mem_kind == KIND_LEFT) begin
                next_strobe = 4'b1111 >> inv_off;
                next_data   = wdata >> {inv_off, 3'b000};
            end else if (mem_kind == KIND_RIGHT) begin
                next_strobe = 4'b1111 << off_in;
                next_data   = wdata << {off_in, 3'b000};
            end else begin
                case (mem_msize)
                    2'd0:    next_strobe = 4'b0001 << off_in;
                    2'd1:    next_strobe = 4'b0011 << off_in;
                    default: next_strobe = 4'b1111;
                endcase
                next_data = wdata << {off_in, 3'b000};
            end
        end
    end

    // Load result: extension for normal loads, byte merge with old rt for LWL/LWR.
    always_comb begin
        shifted     = dresp_data >> {op_off, 3'b000};
        load_result = dresp_data;
        if (op_kind == KIND_LEFT) begin
            case (op_off)
                2'd0:    load_result = {dresp_data[7:0],  op_rt[23:0]};
                2'd1:    load_result = {dresp_data[15:0], op_rt[15:0]};
                2'd2:    load_result = {dresp_data[23:0], op_rt[7:0]};
                default: load_result = dresp_data;
            endcase
        end else if (op_kind == KIND_RIGHT) begin
            case (op_off)
                2'd0:    load_result = dresp_data;
                2'd1:    load_result = {op_rt[31:24], dresp_data[31:8]};
                2'd2:    load_result = {op_rt[31:16], dresp_data[31:16]};
                default: load_result = {op_rt[31:8],  dresp_data[31:24]};
            endcase
        end else begin
            case (op_msize)
                2'd0:    load_result = {{24{op_sig & shifted[7]}}, shifted[7:0]};
                2'd1:    load_result = {{16{op_sig & shifted[15]}}, shifted[15:0]};
                default: load_result = dresp_data;
            endcase
        end
        if (op_write) begin
            load_result = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            op_write    <= 1'b0;
            op_sig      <= 1'b0;
            op_msize    <= 2'd0;
            op_kind     <= 2'd0;
            op_off      <= 2'd0;
            op_rt       <= 32'd0;
            dreq_addr   <= 32'd0;
            dreq_size   <= 2'd0;
            dreq_strobe <= 4'd0;
            dreq_data   <= 32'd0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 32'd0;
            misalign    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            misalign  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_write    <= mem_write;
                        op_sig      <= mem_sig;
                        op_msize    <= mem_msize;
                        op_kind     <= mem_kind;
                        op_off      <= off_in;
                        op_rt       <= rt_old;
                        dreq_addr   <= next_addr;
                        dreq_size   <= next_size;
                        dreq_strobe <= next_strobe;
                        dreq_data   <= next_data;
                        if (is_mis) begin
                            misalign <= 1'b1;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (dreq_addr_ok) begin
                        if (dresp_data_ok) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= load_result;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (dresp_data_ok) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= load_result;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-level reference model,
// randomized ops with random bus stalls, and pinned directed cases.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        mem_write = 1'b0;
    logic        mem_sig = 1'b0;
    logic [1:0]  mem_msize = 2'd0;
    logic [1:0]  mem_kind = 2'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rt_old = 32'd0;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dreq_addr_ok = 1'b0;
    logic        dresp_data_ok = 1'b0;
    logic [31:0] dresp_data = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        misalign;

    mem_access_unit dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .mem_write(mem_write), .mem_sig(mem_sig), .mem_msize(mem_msize), .mem_kind(mem_kind),
        .addr(addr), .wdata(wdata), .rt_old(rt_old),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dreq_addr_ok(dreq_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        write;
        bit        sig;
        bit [1:0]  msize;
        bit [1:0]  kind;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] rt;
    } op_t;

    int checks = 0;
    int failures = 0;

    bit        exp_ready = 1'b1;
    bit        exp_dvalid = 1'b0;
    bit        exp_mis = 1'b0;
    bit        exp_rsp = 1'b0;
    bit        exp_store = 1'b0;
    bit [31:0] exp_addr;
    bit [1:0]  exp_size;
    bit [3:0]  exp_strobe;
    bit [31:0] exp_data;
    bit [31:0] exp_rdata;

    logic [31:0] cap_addr;
    logic [3:0]  cap_strobe;
    logic [31:0] cap_data;
    logic [31:0] cap_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: works byte by byte on little-endian lanes.
    function automatic bit is_misaligned(input op_t op);
        int n = 1 << op.msize;
        return (op.kind == 2'd0) && (op.addr % n != 0) && (op.msize != 2'd0);
    endfunction

    function automatic void model_req(input op_t op, output bit [31:0] a_o, output bit [1:0] s_o,
                                      output bit [3:0] st_o, output bit [31:0] d_o);
        int a = int'(op.addr[1:0]);
        int n = 1 << op.msize;
        st_o = 4'd0;
        d_o  = 32'd0;
        if (op.kind == 2'd0) begin
            a_o = op.addr;
            s_o = op.msize;
            for (int i = 0; i < 4; i++) begin
                if (i >= a) d_o[8*i +: 8] = op.wdata[8*(i-a) +: 8];
                if (i >= a && i < a + n) st_o[i] = op.write;
            end
        end else begin
            a_o = op.addr & 32'hFFFF_FFFC;
            s_o = 2'd2;
            for (int i = 0; i < 4; i++) begin
                if (op.kind == 2'd1 && i <= a) begin
                    d_o[8*i +: 8] = op.wdata[8*(i+3-a) +: 8];
                    st_o[i] = op.write;
                end
                if (op.kind == 2'd2 && i >= a) begin
                    d_o[8*i +: 8] = op.wdata[8*(i-a) +: 8];
                    st_o[i] = op.write;
                end
            end
        end
    endfunction

    function automatic bit [31:0] model_load(input op_t op, input bit [31:0] m);
        int a = int'(op.addr[1:0]);
        int n = 1 << op.msize;
        bit [31:0] res;
        if (op.write) return 32'd0;
        if (op.kind == 2'd1) begin
            res = op.rt;
            for (int i = 0; i <= a; i++) res[8*(3-a+i) +: 8] = m[8*i +: 8];
        end else if (op.kind == 2'd2) begin
            res = op.rt;
            for (int i = a; i < 4; i++) res[8*(i-a) +: 8] = m[8*i +: 8];
        end else begin
            res = 32'd0;
            for (int i = 0; i < n; i++) res[8*i +: 8] = m[8*(a+i) +: 8];
            if (n < 4 && op.sig && res[8*n-1]) begin
                for (int i = 8*n; i < 32; i++) res[i] = 1'b1;
            end
        end
        return res;
    endfunction

    // Per-cycle compare of every output against the model's expectation.
    task automatic check_output();
        @(posedge clk);
        #1;
        chk("req_ready", req_ready, exp_ready);
        chk("dreq_valid", dreq_valid, exp_dvalid);
        chk("misalign", misalign, exp_mis);
        chk("rsp_valid", rsp_valid, exp_rsp);
        if (exp_dvalid) begin
            cap_addr   = dreq_addr;
            cap_strobe = dreq_strobe;
            cap_data   = dreq_data;
            chk("dreq_addr", dreq_addr, exp_addr);
            chk("dreq_size", dreq_size, exp_size);
            chk("dreq_strobe", dreq_strobe, exp_strobe);
            if (exp_store) chk("dreq_data", dreq_data, exp_data);
        end
        if (exp_rsp) begin
            cap_rdata = rsp_data;
            chk("rsp_data", rsp_data, exp_rdata);
        end
    endtask

    task automatic scramble_inputs();
        mem_write = 1'($urandom);
        mem_sig   = 1'($urandom);
        mem_msize = 2'($urandom_range(0, 2));
        mem_kind  = 2'($urandom_range(0, 2));
        addr      = $urandom;
        wdata     = $urandom;
        rt_old    = $urandom;
    endtask

    task automatic apply_stimulus(input op_t op, input int hold, input int wait_n,
                                  input bit same, input bit [31:0] m);
        bit mis = is_misaligned(op);
        cap_addr = 32'hDEAD_0001; cap_strobe = 4'hA; cap_data = 32'hDEAD_0002; cap_rdata = 32'hDEAD_0003;
        model_req(op, exp_addr, exp_size, exp_strobe, exp_data);
        exp_rdata = model_load(op, m);
        exp_store = op.write;
        req_valid = 1'b1;
        mem_write = op.write; mem_sig = op.sig; mem_msize = op.msize; mem_kind = op.kind;
        addr = op.addr; wdata = op.wdata; rt_old = op.rt;
        dreq_addr_ok = 1'b0;
        dresp_data_ok = 1'($urandom);
        dresp_data = $urandom;
        exp_rsp = 1'b0;
        if (mis) begin
            exp_ready = 1'b1; exp_dvalid = 1'b0; exp_mis = 1'b1;
            check_output();
            req_valid = 1'b0;
            scramble_inputs();
            exp_mis = 1'b0;
            check_output();
            dresp_data_ok = 1'b0;
            return;
        end
        exp_ready = 1'b0; exp_dvalid = 1'b1; exp_mis = 1'b0;
        check_output();
        req_valid = 1'($urandom);
        scramble_inputs();
        repeat (hold) begin
            dresp_data_ok = 1'($urandom);
            dresp_data = $urandom;
            check_output();
        end
        dreq_addr_ok = 1'b1;
        if (same) begin
            dresp_data_ok = 1'b1;
            dresp_data = m;
            exp_ready = 1'b1; exp_dvalid = 1'b0; exp_rsp = 1'b1;
            check_output();
        end else begin
            dresp_data_ok = 1'b0;
            exp_dvalid = 1'b0;
            check_output();
            dreq_addr_ok = 1'b0;
            repeat (wait_n) check_output();
            dresp_data_ok = 1'b1;
            dresp_data = m;
            exp_ready = 1'b1; exp_rsp = 1'b1;
            check_output();
        end
        req_valid = 1'b0;
        dreq_addr_ok = 1'b0;
        dresp_data_ok = 1'($urandom);
        dresp_data = $urandom;
        exp_rsp = 1'b0;
        check_output();
        dresp_data_ok = 1'b0;
    endtask

    function automatic op_t mk(input bit w, input bit s, input bit [1:0] sz, input bit [1:0] k,
                               input bit [31:0] a, input bit [31:0] wd, input bit [31:0] rt);
        op_t o;
        o.write = w; o.sig = s; o.msize = sz; o.kind = k; o.addr = a; o.wdata = wd; o.rt = rt;
        return o;
    endfunction

    initial begin
        op_t op;
        #3 resetn = 1'b0;
        #1;
        chk("reset_dreq_valid", dreq_valid, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_misalign", misalign, 1'b0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        check_output();

        // Pinned cases with hand-computed expectations.
        apply_stimulus(mk(0, 1, 2'd0, 2'd0, 32'h1003, 32'h0, 32'h0), 1, 1, 0, 32'h8011_2233);
        chk("lb_addr", cap_addr, 32'h0000_1003);
        chk("lb_strobe", cap_strobe, 4'b0000);
        chk("lb_rdata", cap_rdata, 32'hFFFF_FF80);
        apply_stimulus(mk(1, 0, 2'd1, 2'd0, 32'h2002, 32'h0000_BEEF, 32'h0), 0, 0, 1, 32'h0);
        chk("sh_strobe", cap_strobe, 4'b1100);
        chk("sh_data", cap_data, 32'hBEEF_0000);
        chk("sh_rdata", cap_rdata, 32'h0);
        apply_stimulus(mk(0, 0, 2'd2, 2'd1, 32'h11, 32'h0, 32'hAABB_CCDD), 0, 2, 0, 32'h1122_3344);
        chk("lwl_addr", cap_addr, 32'h0000_0010);
        chk("lwl_rdata", cap_rdata, 32'h3344_CCDD);
        apply_stimulus(mk(0, 0, 2'd2, 2'd2, 32'h11, 32'h0, 32'hAABB_CCDD), 0, 0, 1, 32'h1122_3344);
        chk("lwr_rdata", cap_rdata, 32'hAA11_2233);
        apply_stimulus(mk(0, 0, 2'd2, 2'd0, 32'h6, 32'h0, 32'h0), 0, 0, 0, 32'h0);
        apply_stimulus(mk(1, 0, 2'd2, 2'd0, 32'h40, 32'h1234_5678, 32'h0), 5, 1, 0, 32'h0);
        chk("sw_stall_data", cap_data, 32'h1234_5678);
        apply_stimulus(mk(0, 0, 2'd1, 2'd0, 32'h82, 32'h0, 32'h0), 0, 0, 1, 32'h8765_4321);
        chk("lhu_fast_rdata", cap_rdata, 32'h0000_8765);

        // Reset while waiting for data, then a stray data_ok.
        req_valid = 1'b1; mem_write = 1'b0; mem_msize = 2'd2; mem_kind = 2'd0; addr = 32'h100;
        @(posedge clk); #1;
        req_valid = 1'b0; dreq_addr_ok = 1'b1;
        @(posedge clk); #1;
        dreq_addr_ok = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("rst_wait_dreq_valid", dreq_valid, 1'b0);
        chk("rst_wait_rsp_data", rsp_data, 32'd0);
        @(negedge clk) resetn = 1'b1;
        dresp_data_ok = 1'b1; dresp_data = 32'hCAFE_F00D;
        exp_ready = 1'b1; exp_dvalid = 1'b0; exp_rsp = 1'b0; exp_mis = 1'b0;
        check_output();
        dresp_data_ok = 1'b0;
        check_output();
        chk("rst_wait_rsp_data_after", rsp_data, 32'd0);

        for (int t = 0; t < 200; t++) begin
            op.write = 1'($urandom);
            op.sig   = 1'($urandom);
            op.kind  = 2'($urandom_range(0, 2));
            op.msize = (op.kind == 2'd0) ? 2'($urandom_range(0, 2)) : 2'd2;
            op.addr  = $urandom;
            op.wdata = $urandom;
            op.rt    = $urandom;
            apply_stimulus(op, $urandom_range(0, 4), $urandom_range(0, 3),
                           1'($urandom), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low, ports clk and resetn.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port resetn, input, 1 bit: asynchronous active-low reset.
REQ-004 Port req_valid, input, 1 bit: memory op offered by the execute stage.
REQ-005 Port req_ready, output, 1 bit: high only in IDLE.
REQ-006 Ports mem_write (1 bit), mem_sig (1 bit, 1=signed) and mem_msize (2 bits, 0=1B, 1=2B, 2=4B), inputs: decoded memory arguments.
REQ-007 Port mem_kind, input, 2 bits: 0=normal, 1=left (LWL/SWL), 2=right (LWR/SWR).
REQ-008 Ports addr, wdata and rt_old, inputs, 32 bits each: effective address, store data, and old rt value for LWL/LWR merging.
REQ-009 Ports dreq_valid (1), dreq_addr (32), dreq_size (2), dreq_strobe (4) and dreq_data (32), outputs: data-bus request.
REQ-010 Ports dreq_addr_ok (1), dresp_data_ok (1) and dresp_data (32), inputs: bus address accept, response valid, and read data.
REQ-011 Ports rsp_valid (1), rsp_data (32) and misalign (1), outputs: completion pulse, load result, and address-error pulse.

Function
REQ-012 The block SHALL use a three-state FSM: IDLE, REQ and WAIT.
REQ-013 In IDLE, req_valid high accepts the op; all inputs are latched on that edge.
REQ-014 An accepted op is misaligned when mem_kind is normal and either mem_msize=1 with addr[0]=1, or mem_msize=2 with addr[1:0]≠0.
REQ-015 A misaligned op SHALL pulse misalign for exactly one cycle, on the cycle after acceptance; the FSM stays in IDLE and no bus request is issued.
REQ-016 An aligned op SHALL move the FSM to REQ, where dreq_valid=1 and all dreq_* outputs are held stable until dreq_addr_ok.
REQ-017 In REQ, dreq_addr_ok moves the FSM to WAIT; if dresp_data_ok is high in the same cycle, the FSM moves directly to IDLE and the op completes.
REQ-018 In WAIT, dresp_data_ok moves the FSM to IDLE and completes the op.
REQ-019 On completion, rsp_valid SHALL be a registered one-cycle pulse on the following cycle; minimum latency is acceptance plus 2 cycles.
REQ-020 dresp_data_ok SHALL be ignored in IDLE, and in REQ without dreq_addr_ok; req_valid is ignored while req_ready=0.
REQ-021 dreq_size SHALL equal mem_msize for normal ops and 2 for left/right ops.
REQ-022 dreq_addr SHALL equal addr for normal ops and {addr[31:2],2'b00} for left/right ops.
REQ-023 Byte offset a=addr[1:0]. Normal store strobe: byte 4'b0001<<a; half 4'b0011 (a=0) or 4'b1100 (a=2); word 4'b1111. Store data: wdata<<8a.
REQ-024 SWL: strobe for a=0..3 is 0001/0011/0111/1111; data is wdata>>8(3-a).
REQ-025 SWR: strobe for a=0..3 is 1111/1110/1100/1000; data is wdata<<8a.
REQ-026 For all loads, dreq_strobe=0.
REQ-027 Byte and half loads SHALL extract dresp_data>>8a, then sign- or zero-extend per mem_sig; word loads return dresp_data unchanged.
REQ-028 LWL merge for a=0..3, with m=dresp_data and r=rt_old: {m[7:0],r[23:0]}, {m[15:0],r[15:0]}, {m[23:0],r[7:0]}, m.
REQ-029 LWR merge for a=0..3: m, {r[31:24],m[31:8]}, {r[31:16],m[31:16]}, {r[31:8],m[31:24]}.
REQ-030 For stores, rsp_data SHALL be 0.

Reset
REQ-031 On resetn low, the FSM SHALL go to IDLE and dreq_valid, rsp_valid, misalign and rsp_data SHALL be 0; req_ready=1 after release.
REQ-032 On reset during REQ or WAIT, the in-flight op is dropped; a later stray dresp_data_ok is ignored per REQ-020.

Verification
REQ-033 LB with addr=0x1003, mem_sig=1, dresp_data=0x80112233 -> dreq_addr=0x1003, strobe 0000, rsp_data=0xFFFFFF80.
REQ-034 SH with addr=0x2002, wdata=0x0000BEEF -> strobe 1100, dreq_data=0xBEEF0000, rsp_valid pulses once.
REQ-035 LWL with addr=0x11, rt_old=0xAABBCCDD, mem=0x11223344 -> dreq_addr=0x10, rsp_data=0x3344CCDD; the same case as LWR -> 0xAA112233.
REQ-036 LW with addr=0x6 -> misalign pulses one cycle, dreq_valid stays 0, req_ready=1 the next cycle.
REQ-037 Case 1: dreq_addr_ok held low 5 cycles -> request fields stay stable throughout. Case 2: addr_ok and data_ok in the same cycle -> rsp_valid on the next cycle, total latency 2.
REQ-038 Reset asserted in WAIT, then data_ok after release -> no rsp_valid, FSM in IDLE.
